// File: rtl/upsampling.sv
// upsampling: 2x upsampler for the decoder path.
// Takes a sparse full-frame raster stream at level LEVEL+1 (valid where
// cnt[LEVEL:0] are all ones) and emits a level-LEVEL stream in which each input
// pixel covers its 2x2 output block. A double-banked block-row buffer holds one
// block row while the previous one is read back, so the output lags the input
// by 2^(LEVEL+1) frame lines plus a fixed 2-cycle pipeline.
//
// Ports:
//   clock       single clock
//   n_rst       asynchronous active-low reset
//   in_enable   input pixel valid strobe
//   in_pixels   UNITS channels, channel p at [p*FIXED_BITW +: FIXED_BITW]
//   in_vcnt     full-resolution input row
//   in_hcnt     full-resolution input column
//   out_enable  output pixel valid
//   out_pixels  upsampled pixel
//   out_vcnt    output row  ((in_vcnt - 2^(LEVEL+1)) mod W_HEIGHT, delayed 2)
//   out_hcnt    output column (in_hcnt delayed 2)
//
// Build option: define UPSAMPLE_ZERO_INSERT_EN for zero-insertion upsampling
// (value only at the bottom-right sub-position of each 2x2 block). Without it,
// the value is replicated to all four positions.
module upsampling #(
    parameter int WIDTH      = 16,
    parameter int HEIGHT     = 16,
    parameter int W_WIDTH    = 16,
    parameter int W_HEIGHT   = 16,
    parameter int FIXED_BITW = 8,
    parameter int UNITS      = 2,
    parameter int LEVEL      = 0,
    localparam int unsigned PW = FIXED_BITW * UNITS,
    localparam int unsigned HW = $clog2(W_WIDTH),
    localparam int unsigned VW = $clog2(W_HEIGHT)
) (
    input  logic          clock,
    input  logic          n_rst,
    input  logic          in_enable,
    input  logic [PW-1:0] in_pixels,
    input  logic [VW-1:0] in_vcnt,
    input  logic [HW-1:0] in_hcnt,
    output logic          out_enable,
    output logic [PW-1:0] out_pixels,
    output logic [VW-1:0] out_vcnt,
    output logic [HW-1:0] out_hcnt
);

    localparam int unsigned B     = 1 << (LEVEL + 1);
    localparam int unsigned DEPTH = W_WIDTH >> (LEVEL + 1);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Sub-position masks: input-level block (LEVEL+1 bits) and output-level block (LEVEL bits).
    localparam logic [HW-1:0] H_IN_MASK  = HW'(B - 1);
    localparam logic [VW-1:0] V_IN_MASK  = VW'(B - 1);
    localparam logic [HW-1:0] H_OUT_MASK = HW'((1 << LEVEL) - 1);
    localparam logic [VW-1:0] V_OUT_MASK = VW'((1 << LEVEL) - 1);
    localparam logic [HW-1:0] H_LAST     = HW'(W_WIDTH - 1);

    // Elaboration-time sanity check on the geometry.
    if (WIDTH > W_WIDTH || HEIGHT > W_HEIGHT || LEVEL < 0 || B > W_WIDTH) begin : g_param_check
        $error("upsampling: inconsistent frame geometry parameters");
    end

    logic          wr_c;
    logic          swap_c;
    logic [AW-1:0] addr_c;

    logic          wsel;
    logic [1:0]    filled;
    logic          wr_any;

    logic [PW-1:0] rd_data;
    logic          rd_fill;
    logic [HW-1:0] hcnt_d1;
    logic [VW-1:0] vcnt_d1;
    logic          keep_c;

    logic [PW-1:0] mem [2][DEPTH];

    // Write on the last line/column of each input block; swap banks at the end of a block row.
    assign wr_c   = in_enable
                 && ((in_hcnt & H_IN_MASK) == H_IN_MASK)
                 && ((in_vcnt & V_IN_MASK) == V_IN_MASK);
    assign swap_c = (in_hcnt == H_LAST) && ((in_vcnt & V_IN_MASK) == V_IN_MASK);
    assign addr_c = AW'(in_hcnt >> (LEVEL + 1));

    // Block-row buffer storage; contents are masked by the filled flags, so no reset.
    always_ff @(posedge clock) begin
        if (wr_c) begin
            mem[wsel][addr_c] <= in_pixels;
        end
    end

    // Stage 1: bank control and synchronous read from the bank not being written.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            wsel    <= 1'b0;
            filled  <= 2'b00;
            wr_any  <= 1'b0;
            rd_data <= '0;
            rd_fill <= 1'b0;
            hcnt_d1 <= '0;
            vcnt_d1 <= '0;
        end else begin
            rd_data <= mem[~wsel][addr_c];
            rd_fill <= filled[~wsel];
            hcnt_d1 <= in_hcnt;
            vcnt_d1 <= in_vcnt - VW'(B);
            if (swap_c) begin
                // A write on the swap cycle itself still belongs to the finishing bank.
                filled[wsel] <= wr_any | wr_c;
                wsel         <= ~wsel;
                wr_any       <= 1'b0;
            end else if (wr_c) begin
                wr_any <= 1'b1;
            end
        end
    end

    // Selects which positions of the 2x2 output block carry the buffered value.
`ifdef UPSAMPLE_ZERO_INSERT_EN
    assign keep_c = hcnt_d1[LEVEL] && vcnt_d1[LEVEL];
`else
    assign keep_c = 1'b1;
`endif

    // Stage 2: output register.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            out_enable <= 1'b0;
            out_pixels <= '0;
            out_vcnt   <= '0;
            out_hcnt   <= '0;
        end else begin
            out_enable <= ((hcnt_d1 & H_OUT_MASK) == H_OUT_MASK)
                       && ((vcnt_d1 & V_OUT_MASK) == V_OUT_MASK);
            out_pixels <= (rd_fill && keep_c) ? rd_data : '0;
            out_vcnt   <= vcnt_d1;
            out_hcnt   <= hcnt_d1;
        end
    end

endmodule

// File: tb/tb_upsampling.sv
// tb_upsampling: directed bench for upsampling, a LEVEL=0 and a LEVEL=1 instance
// sharing one 16x16 raster input stream.
module tb_upsampling;

    logic        clock;
    logic        n_rst;
    logic        in_enable;
    logic [15:0] in_pixels;
    logic [3:0]  in_vcnt;
    logic [3:0]  in_hcnt;

    logic        o0_en, o1_en;
    logic [15:0] o0_pix, o1_pix;
    logic [3:0]  o0_v, o0_h, o1_v, o1_h;

    int n_checks;
    int n_fail;
    int cv;
    int ch;

    upsampling #(.LEVEL(0)) dut0 (
        .clock(clock), .n_rst(n_rst), .in_enable(in_enable), .in_pixels(in_pixels),
        .in_vcnt(in_vcnt), .in_hcnt(in_hcnt), .out_enable(o0_en), .out_pixels(o0_pix),
        .out_vcnt(o0_v), .out_hcnt(o0_h)
    );

    upsampling #(.LEVEL(1)) dut1 (
        .clock(clock), .n_rst(n_rst), .in_enable(in_enable), .in_pixels(in_pixels),
        .in_vcnt(in_vcnt), .in_hcnt(in_hcnt), .out_enable(o1_en), .out_pixels(o1_pix),
        .out_vcnt(o1_v), .out_hcnt(o1_h)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected pixel at output position (ov,oh) for a buffered value.
    function automatic logic [15:0] ex(input logic [15:0] val, input int ov, input int oh, input int lvl);
        logic keep;
        keep = (((ov >> lvl) & 1) == 1) && (((oh >> lvl) & 1) == 1);
`ifndef UPSAMPLE_ZERO_INSERT_EN
        keep = 1'b1;
`endif
        return keep ? val : 16'h0000;
    endfunction

    // Drive one raster position, then advance the counters.
    task automatic clk1(input logic en, input logic [15:0] pix);
        in_enable = en;
        in_pixels = pix;
        in_vcnt   = 4'(cv);
        in_hcnt   = 4'(ch);
        @(posedge clock);
        #1;
        ch = ch + 1;
        if (ch == 16) begin
            ch = 0;
            cv = (cv + 1) % 16;
        end
    endtask

    // Idle until input (v,h) is next, then drive it as a valid pixel.
    task automatic go(input int v, input int h, input logic [15:0] pix);
        int n;
        n = 0;
        while (!(cv == v && ch == h) && n < 600) begin
            clk1(1'b0, 16'hDEAD);
            n++;
        end
        check("go_bound", 32'(n < 600), 32'd1);
        clk1(1'b1, pix);
    endtask

    // Idle until the outputs reflect input position (v,h).
    task automatic look(input int v, input int h);
        int n;
        int tgt;
        n   = 0;
        tgt = (v * 16 + h + 2) % 256;
        while ((cv * 16 + ch) != tgt && n < 600) begin
            clk1(1'b0, 16'hDEAD);
            n++;
        end
        check("look_bound", 32'(n < 600), 32'd1);
    endtask

    task automatic chk0(input string tag, input logic en, input logic [15:0] pix, input int ov, input int oh);
        check({tag, ".l0.en"},  32'(o0_en),  32'(en));
        check({tag, ".l0.pix"}, 32'(o0_pix), 32'(pix));
        check({tag, ".l0.v"},   32'(o0_v),   32'(ov));
        check({tag, ".l0.h"},   32'(o0_h),   32'(oh));
    endtask

    task automatic chk1(input string tag, input logic en, input logic [15:0] pix, input int ov, input int oh);
        check({tag, ".l1.en"},  32'(o1_en),  32'(en));
        check({tag, ".l1.pix"}, 32'(o1_pix), 32'(pix));
        check({tag, ".l1.v"},   32'(o1_v),   32'(ov));
        check({tag, ".l1.h"},   32'(o1_h),   32'(oh));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cv        = 0;
        ch        = 0;
        n_rst     = 1'b0;
        in_enable = 1'b0;
        in_pixels = 16'h0000;
        in_vcnt   = 4'd0;
        in_hcnt   = 4'd0;

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        chk0("reset", 1'b0, 16'h0000, 0, 0);
        check("reset.l1.en", 32'(o1_en), 32'd0);
        n_rst = 1'b1;

        // Free-running counters, no data.
        look(0, 5);
        chk0("idle", 1'b1, 16'h0000, 14, 5);
        chk1("idle", 1'b0, 16'h0000, 12, 5);

        // Single pixel at (1,1) replicated to output rows 0/1, cols 0/1.
        go(1, 1, 16'h1122);
        look(2, 0); chk0("p11_00", 1'b1, ex(16'h1122, 0, 0, 0), 0, 0);
        look(2, 1); chk0("p11_01", 1'b1, ex(16'h1122, 0, 1, 0), 0, 1);
        look(3, 0); chk0("p11_10", 1'b1, ex(16'h1122, 1, 0, 0), 1, 0);
        look(3, 1); chk0("p11_11", 1'b1, ex(16'h1122, 1, 1, 0), 1, 1);

        // Last column/row written on the swap cycle; output after frame wrap, sign preserved.
        go(15, 15, 16'h80FF);
        look(0, 14); chk0("p1515_a", 1'b1, ex(16'h80FF, 14, 14, 0), 14, 14);
        look(0, 15); chk0("p1515_b", 1'b1, ex(16'h80FF, 14, 15, 0), 14, 15);
        look(1, 14); chk0("p1515_c", 1'b1, ex(16'h80FF, 15, 14, 0), 15, 14);
        look(1, 15); chk0("p1515_d", 1'b1, ex(16'h80FF, 15, 15, 0), 15, 15);

        // Empty block row: stale RAM content (1122 at addr 0) must be masked.
        look(2, 0); chk0("empty_a", 1'b1, 16'h0000, 0, 0);
        look(3, 1); chk0("empty_b", 1'b1, 16'h0000, 1, 1);

        // Nonzero data, then asynchronous reset mid-row.
        go(5, 1, 16'h5A5A);
        look(6, 1); chk0("p51_a", 1'b1, ex(16'h5A5A, 4, 1, 0), 4, 1);
        look(7, 1); chk0("p51_b", 1'b1, ex(16'h5A5A, 5, 1, 0), 5, 1);
        n_rst = 1'b0;
        #2;
        chk0("async_rst", 1'b0, 16'h0000, 0, 0);
        check("async_rst.l1.en", 32'(o1_en), 32'd0);
        clk1(1'b0, 16'hDEAD);
        clk1(1'b0, 16'hDEAD);
        n_rst = 1'b1;
        look(7, 8); chk0("post_rst_a", 1'b1, 16'h0000, 5, 8);
        look(8, 0); chk0("post_rst_b", 1'b1, 16'h0000, 6, 0);

        // LEVEL=1: value at (3,3) fills a 4x4 output block, valid on odd/odd only.
        go(3, 3, 16'h7F7F);
        look(4, 0); chk1("l1_00", 1'b0, ex(16'h7F7F, 0, 0, 1), 0, 0);
        look(5, 1); chk1("l1_11", 1'b1, ex(16'h7F7F, 1, 1, 1), 1, 1);
        look(5, 3); chk1("l1_13", 1'b1, ex(16'h7F7F, 1, 3, 1), 1, 3);
        look(7, 1); chk1("l1_31", 1'b1, ex(16'h7F7F, 3, 1, 1), 3, 1);
        look(7, 2); chk1("l1_32", 1'b0, ex(16'h7F7F, 3, 2, 1), 3, 2);
        look(7, 3); chk1("l1_33", 1'b1, ex(16'h7F7F, 3, 3, 1), 3, 3);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
